// File: rtl/pc_fetch_sequencer_if.sv
// pc_fetch_sequencer_if: instruction-memory request/response and decode handoff bundle.
interface pc_fetch_sequencer_if #(parameter int RESP_W = 32);
    logic              imem_req_valid;
    logic [63:0]       imem_req_addr;
    logic              imem_req_ready;
    logic              imem_resp_valid;
    logic [RESP_W-1:0] imem_resp_data;
    logic              InstrValid;
    logic [RESP_W-1:0] Instr;
    logic [63:0]       InstrPC;
    logic              InstrReady;
    modport master (
        output imem_req_valid, imem_req_addr, InstrValid, Instr, InstrPC,
        input  imem_req_ready, imem_resp_valid, imem_resp_data, InstrReady
    );
    modport slave (
        input  imem_req_valid, imem_req_addr, InstrValid, Instr, InstrPC,
        output imem_req_ready, imem_resp_valid, imem_resp_data, InstrReady
    );
endinterface

// File: rtl/pc_fetch_sequencer.sv
// pc_fetch_sequencer: PC register and single-outstanding instruction fetch with branch redirect.
module pc_fetch_sequencer #(parameter int RESP_W = 32) (
    input  logic        CLK,
    input  logic        Reset_L,
    input  logic [63:0] startPC,
    input  logic        Stall,
    input  logic        ResolveValid,
    input  logic [63:0] ResolvePC,
    input  logic [63:0] SignExtImm64,
    input  logic        Branch,
    input  logic        ALUZero,
    input  logic        Uncondbranch,
    output logic [63:0] CurrentPC,
    pc_fetch_sequencer_if.master bus
);
    typedef enum logic [2:0] {BOOT, IDLE, REQ, WAIT, DROP, HOLD} state_t;
    state_t state, nxt, resume;
    logic [63:0] pc, pc_nxt, target, instr_pc;
    logic [RESP_W-1:0] instr;
    logic taken, ld, resp;
    assign taken  = ResolveValid & (Uncondbranch | (Branch & ALUZero));
    assign target = ResolvePC + (SignExtImm64 << 2);
    assign resp   = bus.imem_resp_valid;
    assign resume = Stall ? IDLE : REQ;
    assign ld     = (state == WAIT) & resp & !taken;
    // redirect outranks the sequential step everywhere but BOOT
    assign pc_nxt = state == BOOT ? startPC :
                    taken ? target :
                    (state == HOLD && bus.InstrReady) ? pc + 64'd4 : pc;
    always_comb begin
        nxt = state;
        case (state)
            BOOT: nxt = IDLE;
            IDLE: nxt = Stall ? IDLE : REQ;
            REQ:  nxt = bus.imem_req_ready ? (taken ? DROP : WAIT) : REQ;
            WAIT: nxt = taken ? (resp ? resume : DROP) : (resp ? HOLD : WAIT);
            DROP: nxt = resp ? resume : DROP;
            HOLD: nxt = (taken | bus.InstrReady) ? resume : HOLD;
            default: nxt = BOOT;
        endcase
    end
    always_ff @(posedge CLK or negedge Reset_L) begin
        if (!Reset_L) begin
            state    <= BOOT;
            pc       <= '0;
            instr    <= '0;
            instr_pc <= '0;
        end else begin
            state <= nxt;
            pc    <= pc_nxt;
            if (ld) begin
                instr    <= bus.imem_resp_data;
                instr_pc <= pc;
            end
        end
    end
    assign CurrentPC          = pc;
    assign bus.imem_req_valid = state == REQ;
    assign bus.imem_req_addr  = pc;
    assign bus.InstrValid     = state == HOLD;
    assign bus.Instr          = instr;
    assign bus.InstrPC        = instr_pc;
endmodule
